// File: rtl/dmem_pkg.sv
// Shared types and helpers for the multi-cycle data memory responder.
package dmem_pkg;

  localparam int WORD_W = 32;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_e;

  // Ceiling log2; returns 0 for values of 1 or less.
  function automatic int clog2(input int value);
    int v;
    int r;
    r = 0;
    v = value - 1;
    while (v > 0) begin
      r = r + 1;
      v = v >> 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/dmem_array.sv
// Single-port word storage: synchronous write, combinational read of the addressed word.
module dmem_array
  import dmem_pkg::*;
#(
  parameter int DEPTH = 1024,
  parameter int IDX_W = clog2(DEPTH)
) (
  input  logic              clk_i,
  input  logic              we_i,
  input  logic [IDX_W-1:0]  idx_i,
  input  logic [WORD_W-1:0] wdata_i,
  output logic [WORD_W-1:0] rdata_o
);

  // No reset: contents survive rst_i by design.
  logic [WORD_W-1:0] mem_q [DEPTH];

  always_ff @(posedge clk_i) begin
    if (we_i) begin
      mem_q[idx_i] <= wdata_i;
    end
  end

  assign rdata_o = mem_q[idx_i];

endmodule

// File: rtl/dmem_responder.sv
// Multi-cycle data memory responder servicing CPU MEM-stage loads/stores with fixed latency.
// Define DMEM_ALIGN_CHECK_EN to flag misaligned accesses on err_o instead of truncating them.
//
// state | meaning
// IDLE  | waiting for req_i; operands latched when a request is accepted
// BUSY  | access in flight; counter runs down, access commits when it reaches 0
// DONE  | ack_o pulse; req_i ignored (same instruction still in MEM)
module dmem_responder
  import dmem_pkg::*;
#(
  parameter int DEPTH   = 1024,
  parameter int LATENCY = 4,
  parameter int ADDR_W  = 32
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              req_i,
  input  logic              we_i,
  input  logic [ADDR_W-1:0] addr_i,
  input  logic [WORD_W-1:0] wdata_i,
  output logic [WORD_W-1:0] rdata_o,
  output logic              ack_o,
  output logic              stall_o,
  output logic              err_o
);

  localparam int IDX_W = clog2(DEPTH);
  localparam int CNT_W = (LATENCY > 1) ? clog2(LATENCY) : 1;
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(LATENCY - 1);

  state_e            state_q;
  logic [CNT_W-1:0]  cnt_q;
  logic              we_q;
  logic [IDX_W-1:0]  idx_q;
  logic [WORD_W-1:0] wdata_q;
  logic [WORD_W-1:0] rdata_q;
  logic              ack_q;
  logic              commit;
  logic              acc_ok;
  logic              mem_we;
  logic [WORD_W-1:0] mem_rdata;
  logic              unused_addr;

  // Only the word-index bits (and, with alignment checking, bits [1:0]) matter.
  assign unused_addr = ^addr_i;

`ifdef DMEM_ALIGN_CHECK_EN
  logic misalign_q;
  logic err_q;

  assign acc_ok = ~misalign_q;

  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      misalign_q <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      err_q <= 1'b0;
      if (state_q == IDLE && req_i) begin
        misalign_q <= |addr_i[1:0];
      end
      if (commit) begin
        err_q <= misalign_q;
      end
    end
  end

  assign err_o = err_q;
`else
  assign acc_ok = 1'b1;
  assign err_o  = 1'b0;
`endif

  assign commit = (state_q == BUSY) && (cnt_q == '0);

  // Gating with rst_i keeps an abandoned store from landing on the reset edge.
  assign mem_we = commit && we_q && acc_ok && rst_i;

  dmem_array #(
    .DEPTH (DEPTH),
    .IDX_W (IDX_W)
  ) u_array (
    .clk_i   (clk_i),
    .we_i    (mem_we),
    .idx_i   (idx_q),
    .wdata_i (wdata_q),
    .rdata_o (mem_rdata)
  );

  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      we_q    <= 1'b0;
      idx_q   <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      ack_q   <= 1'b0;
    end else begin
      ack_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (req_i) begin
            we_q    <= we_i;
            idx_q   <= addr_i[IDX_W+1:2];
            wdata_q <= wdata_i;
            cnt_q   <= CNT_LOAD;
            state_q <= BUSY;
          end
        end
        BUSY: begin
          if (cnt_q == '0) begin
            ack_q   <= 1'b1;
            state_q <= DONE;
            if (!we_q && acc_ok) begin
              rdata_q <= mem_rdata;
            end
          end else begin
            cnt_q <= cnt_q - CNT_W'(1);
          end
        end
        DONE: begin
          state_q <= IDLE;
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  // The requesting IDLE cycle must already freeze the pipeline.
  assign stall_o = (state_q == BUSY) || ((state_q == IDLE) && req_i);
  assign ack_o   = ack_q;
  assign rdata_o = rdata_q;

endmodule

// File: tb/tb_dmem_responder.sv
// Directed self-checking bench for dmem_responder (DEPTH=1024, LATENCY=4); honours DMEM_ALIGN_CHECK_EN.
module tb_dmem_responder;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req;
  logic        we;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic        ack;
  logic        stall;
  logic        err;

  int n_tests = 0;
  int n_fail  = 0;

  logic [31:0] rd;
  logic        er;
  int          st;
  logic        ak;
  int          ack_seen;
  int          busy_seen;
  int          first_ack;
  int          second_ack;
  logic [31:0] rd1;
  logic [31:0] rd2;

  always #5 clk = ~clk;

  dmem_responder #(
    .DEPTH   (1024),
    .LATENCY (4),
    .ADDR_W  (32)
  ) dut (
    .clk_i   (clk),
    .rst_i   (rst_n),
    .req_i   (req),
    .we_i    (we),
    .addr_i  (addr),
    .wdata_i (wdata),
    .rdata_o (rdata),
    .ack_o   (ack),
    .stall_o (stall),
    .err_o   (err)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
    end
  endtask

  // One complete access, holding req until the ack cycle like the MEM stage does.
  task automatic access(input logic w, input logic [31:0] a, input logic [31:0] wd,
                        output logic [31:0] rd_o, output logic er_o,
                        output int stalls, output logic acked);
    stalls = 0;
    acked  = 1'b0;
    rd_o   = '0;
    er_o   = 1'b0;
    @(negedge clk);
    req = 1'b1; we = w; addr = a; wdata = wd;
    for (int c = 0; c < 20; c++) begin
      #1;
      if (ack) begin
        acked = 1'b1;
        rd_o  = rdata;
        er_o  = err;
        break;
      end
      if (stall) stalls++;
      @(negedge clk);
    end
    req = 1'b0; we = 1'b0;
    @(negedge clk);
    #1;
    check("ack_one_cycle", 32'(ack), 32'd0);
  endtask

  initial begin
    rst_n = 1'b0; req = 1'b0; we = 1'b0; addr = '0; wdata = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("rst_rdata", rdata, 32'h0);
    check("rst_ack", 32'(ack), 32'd0);
    check("rst_stall", 32'(stall), 32'd0);
    check("rst_err", 32'(err), 32'd0);
    busy_seen = 0;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      #1;
      if (stall || ack) busy_seen++;
    end
    check("idle_quiet", 32'(busy_seen), 32'd0);

    // Store then load, latency and hold behaviour
    access(1'b1, 32'h10, 32'hDEADBEEF, rd, er, st, ak);
    check("st10_ack", 32'(ak), 32'd1);
    check("st10_stall_cycles", 32'(st), 32'd5);
    check("st10_err", 32'(er), 32'd0);
    access(1'b0, 32'h10, 32'h0, rd, er, st, ak);
    check("ld10_ack", 32'(ak), 32'd1);
    check("ld10_stall_cycles", 32'(st), 32'd5);
    check("ld10_data", rd, 32'hDEADBEEF);
    repeat (3) @(negedge clk);
    #1;
    check("ld10_hold", rdata, 32'hDEADBEEF);
    access(1'b1, 32'h14, 32'h5A5A5A5A, rd, er, st, ak);
    check("st14_rdata_in_ack", rd, 32'hDEADBEEF);
    check("st14_rdata_after", rdata, 32'hDEADBEEF);

    // Wrap-around modulo DEPTH*4 bytes
    access(1'b1, 32'h1004, 32'h12345678, rd, er, st, ak);
    access(1'b0, 32'h0004, 32'h0, rd, er, st, ak);
    check("wrap_ld4", rd, 32'h12345678);
    access(1'b0, 32'h14, 32'h0, rd, er, st, ak);
    check("wrap_ld14_intact", rd, 32'h5A5A5A5A);

    // Reset in the 2nd BUSY cycle abandons the store
    access(1'b1, 32'h20, 32'h0BADF00D, rd, er, st, ak);
    @(negedge clk);
    req = 1'b1; we = 1'b1; addr = 32'h20; wdata = 32'hAAAA5555;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b0; req = 1'b0; we = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("rstmid_stall", 32'(stall), 32'd0);
    check("rstmid_rdata", rdata, 32'h0);
    ack_seen = 0;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      #1;
      if (ack) ack_seen++;
    end
    check("rstmid_no_ack", 32'(ack_seen), 32'd0);
    access(1'b0, 32'h20, 32'h0, rd, er, st, ak);
    check("rstmid_ld20", rd, 32'h0BADF00D);

    // Back-to-back loads with req held high and operands changing during BUSY
    access(1'b1, 32'h0, 32'hCAFE0000, rd, er, st, ak);
    access(1'b1, 32'h4, 32'h0000BEEF, rd, er, st, ak);
    first_ack = -1; second_ack = -1; rd1 = '0; rd2 = '0;
    @(negedge clk);
    req = 1'b1; we = 1'b0; addr = 32'h0; wdata = 32'h0;
    for (int c = 0; c < 16; c++) begin
      #1;
      if (ack) begin
        if (first_ack < 0) begin
          first_ack = c; rd1 = rdata;
        end else if (second_ack < 0) begin
          second_ack = c; rd2 = rdata;
        end
      end
      @(negedge clk);
      if (c == 0) begin addr = 32'h4; we = 1'b1; wdata = 32'hFFFFFFFF; end
      if (c == 4) we = 1'b0;
      if (c == 10) req = 1'b0;
    end
    check("b2b_first_ack_cycle", 32'(first_ack), 32'd5);
    check("b2b_first_data", rd1, 32'hCAFE0000);
    check("b2b_second_ack_cycle", 32'(second_ack), 32'd11);
    check("b2b_second_data", rd2, 32'h0000BEEF);

`ifdef DMEM_ALIGN_CHECK_EN
    access(1'b1, 32'h22, 32'h11111111, rd, er, st, ak);
    check("mis_st_ack", 32'(ak), 32'd1);
    check("mis_st_err", 32'(er), 32'd1);
    check("mis_st_stall_cycles", 32'(st), 32'd5);
    check("mis_st_rdata", rdata, 32'h0000BEEF);
    #0 check("mis_err_cleared", 32'(err), 32'd0);
    access(1'b0, 32'h20, 32'h0, rd, er, st, ak);
    check("mis_ld20_unchanged", rd, 32'h0BADF00D);
    check("mis_ld20_err", 32'(er), 32'd0);
    access(1'b0, 32'h21, 32'h0, rd, er, st, ak);
    check("mis_ld_err", 32'(er), 32'd1);
    check("mis_ld_rdata_kept", rd, 32'h0BADF00D);
`else
    access(1'b1, 32'h22, 32'h11111111, rd, er, st, ak);
    check("trunc_st_ack", 32'(ak), 32'd1);
    check("trunc_st_err", 32'(er), 32'd0);
    access(1'b0, 32'h20, 32'h0, rd, er, st, ak);
    check("trunc_ld20", rd, 32'h11111111);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/dmem_responder.md
Name: dmem_responder

Overview:
- Multi-cycle data-memory responder. It services the load/store requests that the pipelined CPU's MEM stage issues as initiator.
- It holds a word-addressed storage array and completes each access after a fixed, parameterised latency.
- While an access is in flight it raises stall_o, which freezes the CPU pipeline.
- It replaces the single-cycle data memory when the CPU is built with realistic memory timing.

Parameters:
- DEPTH, 1024: number of 32-bit words in storage; power of two, at least 2.
- LATENCY, 4: number of BUSY cycles per access; minimum 1.
- ADDR_W, 32: width of the byte address input.

Ports:
- clk_i  in  1  clock; all state updates on the rising edge.
- rst_i  in  1  synchronous active-low reset.
- req_i  in  1  access request from the MEM stage; equals MemRead | MemWrite.
- we_i  in  1  1 = store, 0 = load; sampled only with an accepted req_i.
- addr_i  in  ADDR_W  byte address (ALU result).
- wdata_i  in  32  store data.
- rdata_o  out  32  load data, registered.
- ack_o  out  1  one-cycle completion pulse.
- stall_o  out  1  pipeline freeze request.
- err_o  out  1  alignment error flag; see Optional Feature.

Behaviour:
- Reset: rst_i sampled low at a clock edge → state IDLE, counter 0, rdata_o 0, ack_o 0, err_o 0. Storage contents are not cleared.
- Reset mid-operation: the in-flight access is abandoned, no write is committed, and no ack is issued.
- FSM states: IDLE, BUSY, DONE.
- IDLE:
  - req_i=1 → latch we_i, word index and wdata_i; load counter with LATENCY-1; go to BUSY.
  - stall_o = req_i, combinationally, so the requesting cycle already freezes the pipeline.
- BUSY:
  - stall_o=1.
  - Counter decrements each cycle.
  - When counter==0: commit the access at that edge and go to DONE.
    - Store: mem[idx] <= wdata.
    - Load: rdata_o <= mem[idx].
- DONE:
  - ack_o=1, stall_o=0.
  - req_i is ignored: it is the same instruction, still in MEM.
  - Next state is IDLE unconditionally.
- Latency: request first seen in IDLE cycle T → BUSY during T+1..T+LATENCY → DONE (ack) at T+LATENCY+1. Total stall is LATENCY+1 cycles.
- Back-to-back requests: a new request can be accepted in the IDLE cycle immediately after DONE.
- Word index = addr_i[log2(DEPTH)+1:2]. Higher address bits are ignored, so addresses wrap modulo DEPTH*4.
- rdata_o holds its value until the next load commits; stores leave it unchanged.
- Load data is returned from the array as it was at the commit edge. No read-during-write conflict exists, since only one access is outstanding.
- req_i toggling or we_i/addr_i changing during BUSY has no effect; operands were latched at acceptance.

Optional Feature:
- Macro: DMEM_ALIGN_CHECK_EN.
- Defined: an access with latched addr[1:0]!=0 still runs the full latency, but in DONE err_o=1 alongside ack_o. No write is committed and rdata_o is unchanged. err_o is 0 in all other cycles.
- Undefined: addr_i[1:0] is ignored, the access proceeds at the truncated word address, and err_o is tied to 0.

Decomposition:
- Shared package dmem_pkg:
  - state enum {IDLE, BUSY, DONE} (2 bits);
  - WORD_W=32;
  - function clog2 for index width.
- One natural sub-module, dmem_array: single-port synchronous storage (clk, we, idx, wdata, rdata). The FSM, counter and latches stay in dmem_responder.

Test Plan:
- Reset and idle (LATENCY=4): hold rst_i=0 for 2 cycles, then release → rdata_o=0, ack_o=0, stall_o=0, err_o=0; with req_i=0, the state stays IDLE indefinitely.
- Store then load: store 0xDEADBEEF to 0x10 → stall_o high for 5 cycles, ack_o in the 6th. Then load 0x10 → rdata_o=0xDEADBEEF in the ack cycle, and held afterwards.
- Wrap-around (DEPTH=1024): store 0x12345678 to 0x1004, then load 0x0004 → 0x12345678.
- Reset mid-op: store 0xAAAA5555 to 0x20, assert rst_i=0 during the 2nd BUSY cycle → no ack. A subsequent load of 0x20 returns the prior value (0x00000000 if never written).
- Back-to-back requests with operand changes: hold req_i high across two loads of 0x0 and 0x4, and change addr_i during BUSY → first ack returns mem[0]; the second request is accepted the cycle after DONE.
- With DMEM_ALIGN_CHECK_EN: store 0x11111111 to 0x22 → ack_o=1 and err_o=1 in the same cycle; a later load of 0x20 shows the value unchanged.
